mac_seq_ctrl: RTL and testbench

Control sequencer for the MAC datapath: on a start request it clears the accumulator, runs a programmable number of multiply-accumulate steps under a valid/ready operand handshake, drains the MAC pipeline, and signals completion. It is the driving end of the 4-bit step counter interface. It issues `count_enb` and `count_reset` and reads back `count_out` to decide when the vector is finished. It sits between the operand source and the MAC core/counter pair.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_seq_ctrl_if.sv | 38 +++
 rtl/mac_seq_watchdog.sv | 38 +++
 rtl/mac_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and constants for the MAC sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int MAC_COUNT_W     = 4;
    localparam int MAC_PIPE_LAT    = 2;
    localparam int MAC_TIMEOUT_CYC = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mac_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_ctrl_if
// Description : Sequencer bus: start/length request, operand handshake,
//               accumulator and step-counter strobes, status.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_seq_ctrl_if
    import mac_pkg::*;
#(
    parameter int COUNT_W = MAC_COUNT_W
);
    logic               start;
    logic [COUNT_W-1:0] len;
    logic               op_valid;
    logic               op_ready;
    logic               acc_clr;
    logic               acc_en;
    logic               count_enb;
    logic               count_reset;
    logic [COUNT_W-1:0] count_in;
    logic               busy;
    logic               done;
    logic               timeout;

    // The sequencer side.
    modport master (
        input  start, len, op_valid, count_in,
        output op_ready, acc_clr, acc_en, count_enb, count_reset, busy, done, timeout
    );

    // Operand source, MAC core and step counter side.
    modport slave (
        output start, len, op_valid, count_in,
        input  op_ready, acc_clr, acc_en, count_enb, count_reset, busy, done, timeout
    );
endinterface
`default_nettype wire

// File: rtl/mac_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_watchdog
// Description : Stall counter for the RUN state; flags an operand-starvation
//               timeout. Used only when MAC_SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_watchdog
    import mac_pkg::*;
#(
    parameter int TIMEOUT_CYC = MAC_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic starve_i,
    output logic expire_o
);
    localparam int c_STALL_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_STALL_W-1:0] c_LIMIT = c_STALL_W'(TIMEOUT_CYC - 2);

    logic [c_STALL_W-1:0] stall_q;

    // Count consecutive starved RUN cycles; a handshake or leaving RUN restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (run_i && starve_i) begin
            stall_q <= stall_q + c_STALL_W'(1);
        end else begin
            stall_q <= '0;
        end
    end

    // Fire one cycle early so the forced DONE cycle is the TIMEOUT_CYC-th starved cycle.
    assign expire_o = run_i && starve_i && (stall_q == c_LIMIT);
endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_ctrl
// Description : MAC control sequencer: clear, N multiply-accumulate steps
//               under valid/ready, pipeline drain, completion pulse.
//               Optional starvation timeout under macro MAC_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int COUNT_W     = MAC_COUNT_W,
    parameter int PIPE_LAT    = MAC_PIPE_LAT,
    parameter int TIMEOUT_CYC = MAC_TIMEOUT_CYC
) (
    input  logic           clk,
    input  logic           rst,
    mac_seq_ctrl_if.master seq_if
);
    localparam int c_DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD =
        (PIPE_LAT > 0) ? c_DRAIN_W'(PIPE_LAT - 1) : '0;

    mac_seq_state_t       state_q, state_d;
    logic [COUNT_W-1:0]   len_q;
    logic [c_DRAIN_W-1:0] drain_q, drain_d;
    logic                 w_handshake;
    logic                 w_last;
    logic                 w_expire;
    logic                 w_timeout;

    // Termination is decided at the final handshake, so a counter wrap to 0 is harmless.
    assign w_handshake = (state_q == ST_RUN) && seq_if.op_valid;
    assign w_last      = (seq_if.count_in == len_q);

`ifdef MAC_SEQ_TIMEOUT_EN
    logic timeout_q;

    mac_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .run_i    (state_q == ST_RUN),
        .starve_i (!seq_if.op_valid),
        .expire_o (w_expire)
    );

    // Remember that the coming DONE cycle was forced by the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state_q == ST_RUN) && w_expire;
        end
    end

    assign w_timeout = timeout_q;
`else
    assign w_expire  = 1'b0;
    assign w_timeout = 1'b0;
`endif

    // State, latched vector length and drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if ((state_q == ST_IDLE) && seq_if.start) begin
                len_q <= seq_if.len;
            end
        end
    end

    // Next-state and output decode; strobes are state-decoded except the handshake pair.
    always_comb begin
        state_d            = state_q;
        drain_d            = drain_q;
        seq_if.op_ready    = 1'b0;
        seq_if.acc_clr     = 1'b0;
        seq_if.acc_en      = 1'b0;
        seq_if.count_enb   = 1'b0;
        seq_if.count_reset = 1'b0;
        seq_if.busy        = (state_q != ST_IDLE);
        seq_if.done        = 1'b0;
        seq_if.timeout     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (seq_if.start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                seq_if.acc_clr     = 1'b1;
                seq_if.count_reset = 1'b1;
                state_d            = ST_RUN;
            end
            ST_RUN: begin
                seq_if.op_ready  = 1'b1;
                seq_if.acc_en    = w_handshake;
                seq_if.count_enb = w_handshake;
                if (w_handshake && w_last) begin
                    if (PIPE_LAT > 0) begin
                        state_d = ST_DRAIN;
                        drain_d = c_DRAIN_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (w_expire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - c_DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                seq_if.done        = 1'b1;
                seq_if.count_reset = 1'b1;
                seq_if.timeout     = w_timeout;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq_ctrl
// Description : Self-checking bench for mac_seq_ctrl with a step-counter
//               model attached; expected runs are queued per start request.
//               Honours MAC_SEQ_TIMEOUT_EN for the starvation scenario.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    localparam int CW = MAC_COUNT_W;
    localparam int PL = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.COUNT_W(CW)) seq_if ();

    mac_seq_ctrl #(
        .COUNT_W     (CW),
        .PIPE_LAT    (PL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .seq_if (seq_if)
    );

    // Step counter model: enable has priority over synchronous clear.
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cnt_q <= '0;
        else if (seq_if.count_enb)   cnt_q <= cnt_q + 1'b1;
        else if (seq_if.count_reset) cnt_q <= '0;
    end
    assign seq_if.count_in = cnt_q;

    typedef struct {
        int n_hs; int clr_cyc; int first_hs; int last_hs; int done_cyc; bit to;
    } exp_t;

    typedef struct {
        int hs; int clr_cyc; int first_hs; int last_hs; int done_cyc; int done_cnt;
        int busy_lo; int bad; bit to; bit busy0; bit wrap;
    } obs_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Cycle numbers are relative to the cycle in which start is driven.
    function automatic exp_t expect_for(input int l, input int mode);
        exp_t e;
        int   n = l + 1;
        e.clr_cyc = 1;
        e.to      = 1'b0;
        case (mode)
            0: begin e.n_hs = n; e.first_hs = 2; e.last_hs = n + 1; e.done_cyc = n + 2 + PL; end
            1: begin e.n_hs = n; e.first_hs = 2; e.last_hs = 2 * n; e.done_cyc = 2 * n + 1 + PL; end
            default: begin
                e.n_hs = 0; e.first_hs = -1; e.last_hs = -1;
`ifdef MAC_SEQ_TIMEOUT_EN
                e.done_cyc = 1 + TO; e.to = 1'b1;
`else
                e.done_cyc = -1;
`endif
            end
        endcase
        return e;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0: op_valid always 1; 1: alternating 1/0 from cycle 2; 2: never valid.
    // poke re-pulses start (len 0) once in RUN and once in DRAIN.
    task automatic run_op(input int l, input int mode, input int max_cyc, input bit poke, output obs_t o);
        logic [CW-1:0] prev_cnt;
        o = '{default: 0};
        o.clr_cyc = -1; o.first_hs = -1; o.last_hs = -1; o.done_cyc = -1;
        prev_cnt = '0;
        for (int c = 0; c <= max_cyc; c++) begin
            next_cyc();
            seq_if.start = (c == 0) || (poke && ((c == 4) || (c == l + 3)));
            seq_if.len   = (c == 0) ? CW'(l) : '0;
            case (mode)
                0:       seq_if.op_valid = 1'b1;
                1:       seq_if.op_valid = (c >= 2) && (c % 2 == 0);
                default: seq_if.op_valid = 1'b0;
            endcase
            @(negedge clk);
            if (c == 0) o.busy0 = seq_if.busy;
            else if (!seq_if.busy) o.busy_lo++;
            if (seq_if.acc_clr && o.clr_cyc < 0) o.clr_cyc = c;
            if (seq_if.acc_en) begin
                o.hs++;
                if (o.first_hs < 0) o.first_hs = c;
                o.last_hs = c;
            end
            if ((seq_if.acc_en !== seq_if.count_enb) ||
                (seq_if.acc_en !== (seq_if.op_valid & seq_if.op_ready)) ||
                (seq_if.count_enb && seq_if.count_reset) ||
                (seq_if.acc_clr && !seq_if.count_reset)) o.bad++;
            if (c > 0 && prev_cnt == '1 && seq_if.count_in == '0) o.wrap = 1'b1;
            prev_cnt = seq_if.count_in;
            if (seq_if.done) begin
                o.done_cnt++; o.done_cyc = c; o.to = seq_if.timeout;
                break;
            end
        end
        seq_if.start    = 1'b0;
        seq_if.op_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] outs;
        #1 rst = 1'b1;
        #1;
        outs = {seq_if.op_ready, seq_if.acc_clr, seq_if.acc_en, seq_if.count_enb,
                seq_if.count_reset, seq_if.busy, seq_if.done, seq_if.timeout};
        n_chk++; if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: got %b want 00000000", outs); end
        seq_if.start = 1'b1; seq_if.op_valid = 1'b1;
        repeat (3) next_cyc();
        @(negedge clk);
        outs = {seq_if.op_ready, seq_if.acc_clr, seq_if.acc_en, seq_if.count_enb,
                seq_if.count_reset, seq_if.busy, seq_if.done, seq_if.timeout};
        n_chk++; if (outs !== 8'h00) begin n_fail++; $display("FAIL reset_held: got %b want 00000000", outs); end
        next_cyc();
        rst = 1'b0; seq_if.start = 1'b0; seq_if.op_valid = 1'b0;
    endtask

    task automatic test_basic();
        obs_t o; exp_t e;
        exp_q.push_back(expect_for(3, 0));
        run_op(3, 0, 40, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.clr_cyc !== e.clr_cyc) begin n_fail++; $display("FAIL basic_clr_cycle: got %0d want %0d", o.clr_cyc, e.clr_cyc); end
        n_chk++; if (o.first_hs !== e.first_hs) begin n_fail++; $display("FAIL basic_first_acc_en: got %0d want %0d", o.first_hs, e.first_hs); end
        n_chk++; if (o.last_hs !== e.last_hs) begin n_fail++; $display("FAIL basic_last_acc_en: got %0d want %0d", o.last_hs, e.last_hs); end
        n_chk++; if (o.hs !== e.n_hs) begin n_fail++; $display("FAIL basic_handshakes: got %0d want %0d", o.hs, e.n_hs); end
        n_chk++; if (o.done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want %0d", o.done_cyc, e.done_cyc); end
        n_chk++; if (o.to !== e.to) begin n_fail++; $display("FAIL basic_timeout: got %0b want %0b", o.to, e.to); end
        n_chk++; if (o.bad !== 0 || o.busy_lo !== 0 || o.busy0 !== 1'b0) begin n_fail++; $display("FAIL basic_strobes: bad=%0d busy_lo=%0d busy0=%0b want 0 0 0", o.bad, o.busy_lo, o.busy0); end
        next_cyc();
        @(negedge clk);
        n_chk++; if ({seq_if.busy, seq_if.done} !== 2'b00) begin n_fail++; $display("FAIL basic_busy_after_done: got busy=%0b done=%0b want 0 0", seq_if.busy, seq_if.done); end
    endtask

    task automatic test_alternating();
        obs_t o; exp_t e;
        exp_q.push_back(expect_for(3, 1));
        run_op(3, 1, 40, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.hs !== e.n_hs) begin n_fail++; $display("FAIL alt_handshakes: got %0d want %0d", o.hs, e.n_hs); end
        n_chk++; if (o.last_hs !== e.last_hs) begin n_fail++; $display("FAIL alt_last_acc_en: got %0d want %0d", o.last_hs, e.last_hs); end
        n_chk++; if (o.done_cyc - o.last_hs !== PL + 1) begin n_fail++; $display("FAIL alt_done_gap: got %0d want %0d", o.done_cyc - o.last_hs, PL + 1); end
        n_chk++; if (o.bad !== 0) begin n_fail++; $display("FAIL alt_strobes: got %0d bad cycles want 0", o.bad); end
    endtask

    task automatic test_wrap();
        obs_t o; exp_t e; int extra;
        exp_q.push_back(expect_for(15, 0));
        run_op(15, 0, 60, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.hs !== e.n_hs) begin n_fail++; $display("FAIL wrap_handshakes: got %0d want %0d", o.hs, e.n_hs); end
        n_chk++; if (o.wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_counter: got wrap=%0b want 1", o.wrap); end
        n_chk++; if (o.done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want %0d", o.done_cyc, e.done_cyc); end
        extra = 0;
        seq_if.op_valid = 1'b1;
        repeat (3) begin
            next_cyc();
            @(negedge clk);
            if (seq_if.acc_en || seq_if.done) extra++;
        end
        seq_if.op_valid = 1'b0;
        n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL wrap_extra_strobes: got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2; exp_t e;
        exp_q.push_back(expect_for(0, 0));
        run_op(0, 0, 20, 1'b0, o1);
        exp_q.push_back(expect_for(2, 0));
        run_op(2, 0, 20, 1'b0, o2);
        e = exp_q.pop_front();
        n_chk++; if (o1.done_cyc !== e.done_cyc || o1.hs !== e.n_hs) begin n_fail++; $display("FAIL b2b_first: got done=%0d hs=%0d want done=%0d hs=%0d", o1.done_cyc, o1.hs, e.done_cyc, e.n_hs); end
        e = exp_q.pop_front();
        n_chk++; if (o2.busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_low: got %0b want 0", o2.busy0); end
        n_chk++; if (o2.clr_cyc !== e.clr_cyc) begin n_fail++; $display("FAIL b2b_clr_cycle: got %0d want %0d", o2.clr_cyc, e.clr_cyc); end
        n_chk++; if (o2.done_cyc !== e.done_cyc || o2.hs !== e.n_hs) begin n_fail++; $display("FAIL b2b_second: got done=%0d hs=%0d want done=%0d hs=%0d", o2.done_cyc, o2.hs, e.done_cyc, e.n_hs); end
    endtask

    task automatic test_start_ignored();
        obs_t o; exp_t e; int extra;
        exp_q.push_back(expect_for(5, 0));
        run_op(5, 0, 40, 1'b1, o);
        e = exp_q.pop_front();
        n_chk++; if (o.hs !== e.n_hs) begin n_fail++; $display("FAIL ignore_handshakes: got %0d want %0d", o.hs, e.n_hs); end
        n_chk++; if (o.done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d want %0d", o.done_cyc, e.done_cyc); end
        extra = 0;
        repeat (4) begin
            next_cyc();
            @(negedge clk);
            if (seq_if.done || seq_if.busy) extra++;
        end
        n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_single_done: got %0d busy/done cycles want 0", extra); end
    endtask

    task automatic test_async_reset();
        obs_t o; exp_t e; int hs; logic [7:0] outs;
        hs = 0;
        for (int c = 0; c < 4; c++) begin
            next_cyc();
            seq_if.start    = (c == 0);
            seq_if.len      = CW'(5);
            seq_if.op_valid = 1'b1;
            @(negedge clk);
            if (seq_if.acc_en) hs++;
        end
        n_chk++; if (hs !== 2) begin n_fail++; $display("FAIL areset_pre_handshakes: got %0d want 2", hs); end
        #2 rst = 1'b1;
        #1;
        outs = {seq_if.op_ready, seq_if.acc_clr, seq_if.acc_en, seq_if.count_enb,
                seq_if.count_reset, seq_if.busy, seq_if.done, seq_if.timeout};
        n_chk++; if (outs !== 8'h00) begin n_fail++; $display("FAIL areset_outputs: got %b want 00000000", outs); end
        next_cyc();
        next_cyc();
        rst = 1'b0; seq_if.op_valid = 1'b0;
        exp_q.push_back(expect_for(1, 0));
        run_op(1, 0, 20, 1'b0, o);
        e = exp_q.pop_front();
        n_chk++; if (o.hs !== e.n_hs || o.done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL areset_restart: got hs=%0d done=%0d want hs=%0d done=%0d", o.hs, o.done_cyc, e.n_hs, e.done_cyc); end
    endtask

    task automatic test_starve();
        obs_t o; exp_t e;
        exp_q.push_back(expect_for(3, 2));
`ifdef MAC_SEQ_TIMEOUT_EN
        run_op(3, 2, TO + 20, 1'b0, o);
`else
        run_op(3, 2, 200, 1'b0, o);
`endif
        e = exp_q.pop_front();
        n_chk++; if (o.done_cyc !== e.done_cyc) begin n_fail++; $display("FAIL starve_done_cycle: got %0d want %0d", o.done_cyc, e.done_cyc); end
        n_chk++; if (o.to !== e.to) begin n_fail++; $display("FAIL starve_timeout: got %0b want %0b", o.to, e.to); end
        n_chk++; if (o.hs !== 0 || o.busy_lo !== 0) begin n_fail++; $display("FAIL starve_run: got hs=%0d busy_lo=%0d want 0 0", o.hs, o.busy_lo); end
        next_cyc();
        @(negedge clk);
`ifdef MAC_SEQ_TIMEOUT_EN
        n_chk++; if (seq_if.busy !== 1'b0) begin n_fail++; $display("FAIL starve_idle: got busy=%0b want 0", seq_if.busy); end
`else
        n_chk++; if (seq_if.op_ready !== 1'b1) begin n_fail++; $display("FAIL starve_waiting: got op_ready=%0b want 1", seq_if.op_ready); end
`endif
        #2 rst = 1'b1;
        next_cyc();
        rst = 1'b0;
    endtask

    initial begin
        seq_if.start    = 1'b0;
        seq_if.len      = '0;
        seq_if.op_valid = 1'b0;
        test_reset();
        test_basic();
        test_alternating();
        test_wrap();
        test_back_to_back();
        test_start_ignored();
        test_async_reset();
        test_starve();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish within 200000 ns");
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire
